// File: rtl/lock_entry_sequencer_pkg.sv
// rtl/lock_entry_sequencer_pkg.sv - shared types, defaults and width helpers for the lock sequencer
// Purpose: state encoding for the entry FSM, default parameter values and the
//          width helpers used to size the failure counter and the shared timer.
// Ports:   none (package).
package lock_entry_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RELOCK  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_CHECK   = 3'd5,
        ST_OPEN    = 3'd6,
        ST_LOCKOUT = 3'd7
    } lock_state_t;

    localparam int DEF_CODE_W      = 3;
    localparam int DEF_MAX_FAILS   = 3;
    localparam int DEF_LOCKOUT_CYC = 16;
    localparam int DEF_UNLOCK_CYC  = 8;
    localparam int DEF_SETTLE_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Failure counter must hold 0..max_fails inclusive.
    function automatic int fail_w(input int max_fails);
        return (max_fails > 1) ? $clog2(max_fails + 1) : 1;
    endfunction

    // Timer holds N-1 of the longest window.
    function automatic int timer_w(input int lockout_cyc, input int unlock_cyc, input int settle_cyc);
        int w;
        w = $clog2(max3(lockout_cyc, unlock_cyc, settle_cyc) + 1);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/lock_entry_sequencer_if.sv
// rtl/lock_entry_sequencer_if.sv - code attempt / verdict handshake bundle
// Purpose: groups the attempt offer (code_valid/code_in/code_ready) and the
//          verdict pulse (result_valid/result_pass) between a requester and the sequencer.
// Ports:   master drives code_valid, code_in and observes code_ready, result_valid, result_pass;
//          slave is the sequencer side.
interface lock_entry_sequencer_if #(
    parameter int CODE_W = 3
) ();
    logic              code_valid;
    logic [CODE_W-1:0] code_in;
    logic              code_ready;
    logic              result_valid;
    logic              result_pass;

    modport master (
        output code_valid,
        output code_in,
        input  code_ready,
        input  result_valid,
        input  result_pass
    );

    modport slave (
        input  code_valid,
        input  code_in,
        output code_ready,
        output result_valid,
        output result_pass
    );
endinterface

// File: rtl/lock_entry_sequencer_cycle_timer.sv
// rtl/lock_entry_sequencer_cycle_timer.sv - loadable down-counter with expire flag
// Purpose: one timer shared by the SETTLE, OPEN and LOCKOUT windows. Loaded with N-1
//          on window entry, it reads expired during the Nth cycle of the window.
// Ports:   clk, clr (sync active-high), load, load_val[W-1:0] in; expired out.
module lock_cycle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/lock_entry_sequencer.sv
// rtl/lock_entry_sequencer.sv - sequences code entry into the serial combination-lock datapath
// Purpose: accepts a parallel code attempt, clears the datapath, shifts the code MSB first,
//          samples the unlock indication and reports pass/fail; tracks consecutive failures
//          with a timed lockout and auto-relocks after a timed open window.
// Ports:   clk, clr (sync active-high reset)
//          code_if (slave): code_valid, code_in, code_ready, result_valid, result_pass
//          lock_data, lock_clr_n out to datapath; lock_unlocked in from datapath
//          relock in (early close of open window)
//          door_open, lockout, fail_cnt[FW-1:0] status out
module lock_entry_sequencer
    import lock_entry_sequencer_pkg::*;
#(
    parameter int CODE_W      = DEF_CODE_W,
    parameter int MAX_FAILS   = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter int UNLOCK_CYC  = DEF_UNLOCK_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
    input  logic                           clk,
    input  logic                           clr,
    lock_entry_sequencer_if.slave          code_if,
    output logic                           lock_data,
    output logic                           lock_clr_n,
    input  logic                           lock_unlocked,
    input  logic                           relock,
    output logic                           door_open,
    output logic                           lockout,
    output logic [fail_w(MAX_FAILS)-1:0]   fail_cnt
);

    localparam int FW = fail_w(MAX_FAILS);
    localparam int TW = timer_w(LOCKOUT_CYC, UNLOCK_CYC, SETTLE_CYC);
    localparam int IW = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(CODE_W - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] UNLOCK_LD = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_CYC - 1);

    lock_state_t       state_q, state_d;
    logic [CODE_W-1:0] code_sh_q;
    logic [IW-1:0]     bit_idx_q;
    logic [FW-1:0]     fail_q;
    logic [FW-1:0]     fail_inc;
    logic              unlk_q;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_expired;

    lock_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Saturating next failure count; lockout fires when it reaches the limit.
    assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RELOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The verdict uses unlk_q, the unlock flag registered during the
    // last SETTLE cycle; the datapath is static after the final shift, so this is the
    // same value the datapath shows in CHECK while keeping result_pass a pure register decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RELOCK:  state_d = ST_IDLE;
            ST_IDLE:    if (code_if.code_valid) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = ST_SHIFT;
            ST_SHIFT:   if (bit_idx_q == LAST_IDX) state_d = ST_SETTLE;
            ST_SETTLE:  if (tmr_expired) state_d = ST_CHECK;
            ST_CHECK: begin
                if (unlk_q) begin
                    state_d = ST_OPEN;
                end else if (fail_inc == FAIL_MAX) begin
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d = ST_RELOCK;
                end
            end
            // Expiry and relock in the same cycle collapse into one transition.
            ST_OPEN:    if (tmr_expired || relock) state_d = ST_RELOCK;
            ST_LOCKOUT: if (tmr_expired) state_d = ST_RELOCK;
            default:    state_d = ST_RELOCK;
        endcase
    end

    // Timer load on entry to a timed window.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_d != state_q) begin
            case (state_d)
                ST_SETTLE: begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
                ST_OPEN: begin
                    tmr_load = 1'b1;
                    tmr_val  = UNLOCK_LD;
                end
                ST_LOCKOUT: begin
                    tmr_load = 1'b1;
                    tmr_val  = LOCKOUT_LD;
                end
                default: begin
                    tmr_load = 1'b0;
                    tmr_val  = '0;
                end
            endcase
        end
    end

    // Code shift register, bit index, failure count, registered unlock flag.
    always_ff @(posedge clk) begin
        if (clr) begin
            code_sh_q <= '0;
            bit_idx_q <= '0;
            fail_q    <= '0;
            unlk_q    <= 1'b0;
        end else begin
            unlk_q <= lock_unlocked;
            case (state_q)
                ST_IDLE: begin
                    if (code_if.code_valid) code_sh_q <= code_if.code_in;
                end
                ST_CLEAR: begin
                    bit_idx_q <= '0;
                end
                ST_SHIFT: begin
                    code_sh_q <= code_sh_q << 1;
                    bit_idx_q <= bit_idx_q + IW'(1);
                end
                ST_CHECK: begin
                    fail_q <= unlk_q ? '0 : fail_inc;
                end
                ST_LOCKOUT: begin
                    if (tmr_expired) fail_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        code_if.code_ready   = (state_q == ST_IDLE);
        code_if.result_valid = (state_q == ST_CHECK);
        code_if.result_pass  = (state_q == ST_CHECK) && unlk_q;
        lock_clr_n           = !((state_q == ST_RELOCK) || (state_q == ST_CLEAR));
        lock_data            = (state_q == ST_SHIFT) && code_sh_q[CODE_W-1];
        door_open            = (state_q == ST_OPEN);
        lockout              = (state_q == ST_LOCKOUT);
    end

    assign fail_cnt = fail_q;

endmodule
